mem_block_mover: RTL
====================

// Module: mem_block_mover
// PURPOSE
//  Initiator (bus master) for the single-port 32x8 data memory.
//  Performs block copy (src->dst) or block fill (constant->dst) of up to LEN bytes.
//  Drives the memory's address / writeData / memRead / memWrite port and consumes its
//  combinational read data.
//  Sits beside the CPU datapath; the CPU's memory port is muxed out while busy=1.
// PARAMETERS
//  ADDR_W  5  memory address width; depth = 2**ADDR_W = 32, addresses wrap modulo depth
//  DATA_W  8  memory word width
//  LEN_W   6  transfer-length width (0..63 bytes)
// PORTS
//  clk             in   1       clock, rising edge
//  rst             in   1       reset, asynchronous, active-high
//  start           in   1       request pulse, sampled only in IDLE
//  op              in   1       0 = copy, 1 = fill
//  src_addr        in   ADDR_W  copy source base (ignored for fill)
//  dst_addr        in   ADDR_W  destination base
//  length          in   LEN_W   byte count
//  fill_value      in   DATA_W  fill constant
//  busy            out  1       operation in progress
//  done            out  1       one-cycle completion pulse
//  mem_address     out  ADDR_W  to memory address
//  mem_write_data  out  DATA_W  to memory writeData
//  mem_read        out  1       to memory memRead
//  mem_write       out  1       to memory memWrite
//  mem_rdata       in   DATA_W  from memory out (combinational read of mem_address)
// BEHAVIOUR
//  - Reset (async): state=IDLE; all outputs 0; internal counters and data regs 0.
//  - Input latching: start in IDLE latches op, src, dst, length and fill_value.
//    Later input changes have no effect on the running operation.
//  - start outside IDLE is ignored (this includes DONE).
//  - FSM states: IDLE, RD, WR, DONE.
//  - IDLE & start:
//    - length==0 -> DONE
//    - op==copy  -> RD
//    - op==fill  -> WR
//  - RD (copy only):
//    - mem_address = src + i; mem_read = 1.
//    - mem_rdata is captured into data_q at the rising edge; next state = WR.
//  - WR:
//    - mem_address = dst + i; mem_write = 1.
//    - mem_write_data = data_q (copy) or fill_value (fill).
//    - At the edge: i <= i + 1.
//    - If i+1 == length -> DONE; else RD (copy) or WR (fill).
//  - DONE: done = 1 for exactly one cycle, busy = 0, then IDLE.
//  - busy = 1 in RD and WR only.
//  - Output decode: mem_* and busy/done are decoded from registered state only.
//    There is no combinational path from start or any other input to the outputs.
//  - Address arithmetic: (base + i) truncated to ADDR_W bits, so addresses wrap 31 -> 0.
//  - i is LEN_W bits wide. length > 32 is legal and revisits addresses.
//  - Latency from the edge that samples start to the done cycle:
//    - copy: 2N access cycles, done in cycle 2N+1
//    - fill: N access cycles, done in cycle N+1
//    - length == 0: done in cycle 1
//  - Overlap: copy is strictly ascending, one byte read then that byte written.
//    With dst > src and overlapping ranges, propagation of already-written bytes is the
//    required behaviour. No reverse-direction mode.
//  - mem_read and mem_write are never both 1 in the same cycle.
//  - rst mid-operation: outputs drop to 0 immediately (async).
//    - The write of the current WR cycle is not committed.
//    - Bytes written in earlier cycles remain.
// STRUCTURE
//  - Shared package mem_pkg holds:
//    - ADDR_W, DATA_W, MEM_DEPTH
//    - typedef op_e {OP_COPY, OP_FILL}
//    - typedef state_e {IDLE, RD, WR, DONE}
//    - the CPU/mover port-mux select encoding
//  - Flat module; no sub-module is warranted.
//  - The index counter and the address adders are inline.
// TESTING (bench instantiates the data memory with mem[25..29] = 9,7,5,3,1)
//  1. copy src=25 dst=5 len=5
//     -> mem[5..9] = 9,7,5,3,1; 10 access cycles alternating rd/wr; done in cycle 11.
//  2. fill dst=10 len=4 value=8'hAA
//     -> mem[10..13] = AA; mem_read never 1; done in cycle 5; mem[14] unchanged.
//  3. fill dst=30 len=4 value=8'h55 (wrap)
//     -> mem[30], mem[31], mem[0], mem[1] = 55; mem_address sequence 30,31,0,1.
//  4. copy len=0 -> no mem_read/mem_write asserted; done pulse in cycle 1; busy stays 0.
//  5. start during busy with different params -> ignored; first op's results intact.
//     A new start is accepted only after done, once back in IDLE.
//  6. rst asserted mid-copy during the 3rd WR cycle (src=25 dst=5 len=5)
//     -> outputs 0 at once; mem[5], mem[6] = 9,7 and mem[7] not written (memory rst
//        kept low); FSM in IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data memory and its bus initiators:
// memory geometry, operation and FSM encodings, CPU/mover port-mux select.
package mem_pkg;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 8;
  localparam int LEN_W     = 6;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  typedef enum logic {
    OP_COPY = 1'b0,
    OP_FILL = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  // Memory port ownership: the mover takes the port while its busy is high.
  typedef enum logic {
    SEL_CPU   = 1'b0,
    SEL_MOVER = 1'b1
  } port_sel_e;

endpackage

// File: rtl/mem_block_mover.sv
// Bus initiator for the single-port data memory: block copy (src->dst, one read
// then one write per byte, ascending) or block fill of a constant into dst.
module mem_block_mover #(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int LEN_W  = mem_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  import mem_pkg::*;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  i_q, i_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [LEN_W-1:0]  i_inc;

  assign i_inc = i_q + LEN_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_COPY;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      i_q     <= '0;
      data_q  <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      i_q     <= i_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    i_d     = i_q;
    data_d  = data_q;
    fill_d  = fill_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op_e'(op);
          src_d  = src_addr;
          dst_d  = dst_addr;
          len_d  = length;
          fill_d = fill_value;
          i_d    = '0;
          if (length == '0)
            state_d = DONE;
          else if (op_e'(op) == OP_COPY)
            state_d = RD;
          else
            state_d = WR;
        end
      end
      RD: begin
        data_d  = mem_rdata;
        state_d = WR;
      end
      WR: begin
        i_d = i_inc;
        if (i_inc == len_q)
          state_d = DONE;
        else if (op_q == OP_COPY)
          state_d = RD;
        else
          state_d = WR;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decode from registered state only, so an async reset clears them at once.
  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    unique case (state_q)
      RD: begin
        busy        = 1'b1;
        mem_read    = 1'b1;
        mem_address = src_q + i_q[ADDR_W-1:0];
      end
      WR: begin
        busy           = 1'b1;
        mem_write      = 1'b1;
        mem_address    = dst_q + i_q[ADDR_W-1:0];
        mem_write_data = (op_q == OP_FILL) ? fill_q : data_q;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule
